sha256_round_engine: RTL and testbench
======================================

// Module: sha256_round_engine
// PURPOSE
//  Parametrised SHA-256 compression engine: one 512-bit block + 256-bit chaining value -> 256-bit digest.
//  Owns message schedule, K ROM, round counter and start/done handshake; UNROLL rounds per clock.
//  Sits between block formatter (padding/midstate) and nonce-check logic in the hash pipeline.
// PARAMETERS
//  UNROLL   1  rounds per clock; legal 1,2,4,8 (64 % UNROLL == 0), else elaboration error
//  OUT_REG  1  1: digest/done registered after FINAL; 0: driven from FINAL-state logic, one cycle earlier
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    async active-low reset
//  start     in   1    request; accepted on edge where start && ready
//  abort     in   1    sync cancel of in-flight block
//  h_in      in   256  chaining value, H0 in [255:224] ... H7 in [31:0]
//  block_in  in   512  message block, W0 in [511:480] ... W15 in [31:0]
//  ready     out  1    engine idle, start will be accepted
//  digest    out  256  result, same word order as h_in
//  done      out  1    one-cycle pulse, digest valid this cycle
// BEHAVIOUR
//  Reset: state IDLE, ready=1, done=0, digest=0, a..h=0, schedule=0, round count=0; async assert, sync release.
//  FSM IDLE -> ROUND -> FINAL -> IDLE.
//  IDLE: start&&ready -> latch h_in, load a..h<-h_in, W window<-block_in, cnt<-0, ready<=0, go ROUND.
//  ROUND: each edge applies rounds cnt..cnt+UNROLL-1; cnt+=UNROLL; cnt==64-UNROLL on edge -> FINAL.
//  FINAL: one edge computing digest (see CONFIGURATION); go IDLE, ready<=1.
//  Latency: OUT_REG=1 -> done high 64/UNROLL+2 cycles after accepting edge (UNROLL=1: 66); OUT_REG=0 -> one fewer.
//  Schedule: 16-word sliding window; rounds 0..15 use block words; round t>=16 uses
//   W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16]; s0=ROTR7^ROTR18^SHR3, s1=ROTR17^ROTR19^SHR10.
//  Round: T1=h+S1(e)+Ch(e,f,g)+K[t]+W[t], T2=S0(a)+Maj(a,b,c); a<-T1+T2, e<-d+T1, rest shift.
//   S0=ROTR2^13^22, S1=ROTR6^11^25. All adds mod 2^32; no carry out.
//  K ROM: combinational, indexed by round number t (no offset); 64 FIPS 180-4 constants.
//  Unrolled rounds chained combinationally within one cycle; round t uses K[t], W[t] exactly.
//  start while !ready: ignored, no queueing; h_in/block_in may change freely after accept.
//  abort in ROUND/FINAL: next edge -> IDLE, ready=1, no done, digest holds previous value.
//  abort && start same edge in IDLE: abort wins, nothing accepted.
//  start on the edge done pulses (ready=1): accepted; back-to-back blocks, no idle bubble beyond FINAL.
//  digest holds last result until next completion; done never high two consecutive cycles.
//  rst_n low mid-block: everything to reset values immediately; no done afterwards.
// CONFIGURATION
//  SHA256_FEEDFWD_EN defined: digest = latched h_in + final a..h (per word mod 2^32), standard compression.
//  SHA256_FEEDFWD_EN undefined: digest = final a..h raw (working variables), adders removed;
//   caller performs feed-forward externally. Latency and handshake identical either way.
// TESTING
//  Run all scenarios for UNROLL=1,2,4,8, OUT_REG=0/1, macro defined (1-5) and undefined (6).
//  1 "abc": h_in=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19,
//    block=61626380,0x0 x14,00000018 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  2 empty string: same h_in, block=80000000,0 x15 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924
//    27ae41e4 649b934c a495991b 7852b855; done exactly 66 cycles after accept (UNROLL=1, OUT_REG=1).
//  3 back-to-back: "abc" then start on done cycle with empty-string block -> two done pulses, correct digests, gap 66.
//  4 start held high during run, block_in changed mid-run -> ignored, "abc" digest unaffected.
//  5 abort at round 30 -> no done, ready=1 next cycle, digest keeps prior value; re-run "abc" correct.
//  6 rst_n low at round 40 -> ready=1, done=0, digest=0 immediately; macro undefined: "abc" digest =
//    expected minus H0 per word (ba7816bf-6a09e667=506e3058 first word).

Source files
------------

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one block plus chaining value to digest, UNROLL rounds per clock.
// Define SHA256_FEEDFWD_EN to add the chaining value back in (standard digest); otherwise a..h raw.
module sha256_round_engine #(
    parameter int UNROLL  = 1,
    parameter int OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] h_in,
    input  logic [511:0] block_in,
    output logic         ready,
    output logic [255:0] digest,
    output logic         done
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
    end
    if (!(OUT_REG == 0 || OUT_REG == 1)) begin : g_bad_out_reg
        $error("sha256_round_engine: OUT_REG must be 0 or 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);
    localparam logic [5:0] STEP     = 6'(UNROLL);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       state;
    logic [5:0]   cnt;
    logic [31:0]  v [8];
    logic [31:0]  w [16];
    logic [255:0] digest_q;
    logic         done_q;
    logic         fin;
    logic [255:0] res;

    logic [31:0]  v_nx [8];
    logic [31:0]  w_nx [16];
    logic [5:0]   t;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [31:0]  w16;

`ifdef SHA256_FEEDFWD_EN
    logic [31:0]  h_lat [8];
`endif

    // Window w[0] always holds W[t] for the round being applied; each round
    // also produces W[t+16] so the window slides by one word per round.
    always_comb begin
        v_nx = v;
        w_nx = w;
        t    = '0;
        t1   = '0;
        t2   = '0;
        w16  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            t   = cnt + 6'(u);
            t1  = v_nx[7] + big_s1(v_nx[4])
                + ((v_nx[4] & v_nx[5]) ^ (~v_nx[4] & v_nx[6]))
                + K[t] + w_nx[0];
            t2  = big_s0(v_nx[0])
                + ((v_nx[0] & v_nx[1]) ^ (v_nx[0] & v_nx[2]) ^ (v_nx[1] & v_nx[2]));
            w16 = sml_s1(w_nx[14]) + w_nx[9] + sml_s0(w_nx[1]) + w_nx[0];
            for (int i = 7; i > 0; i--) begin
                v_nx[i] = v_nx[i-1];
            end
            v_nx[0] = t1 + t2;
            v_nx[4] = v_nx[4] + t1;
            for (int i = 0; i < 15; i++) begin
                w_nx[i] = w_nx[i+1];
            end
            w_nx[15] = w16;
        end
    end

    always_comb begin
        res = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFWD_EN
            res[255-32*i -: 32] = h_lat[i] + v[i];
`else
            res[255-32*i -: 32] = v[i];
`endif
        end
    end

    assign fin    = (state == FINAL) && !abort;
    assign done   = (OUT_REG != 0) ? done_q : fin;
    assign digest = (OUT_REG == 0 && fin) ? res : digest_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            done_q   <= 1'b0;
            digest_q <= '0;
            for (int i = 0; i < 8; i++) begin
                v[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
`ifdef SHA256_FEEDFWD_EN
            for (int i = 0; i < 8; i++) begin
                h_lat[i] <= '0;
            end
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && ready && !abort) begin
                        for (int i = 0; i < 8; i++) begin
                            v[i] <= h_in[255-32*i -: 32];
                        end
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= block_in[511-32*i -: 32];
                        end
`ifdef SHA256_FEEDFWD_EN
                        for (int i = 0; i < 8; i++) begin
                            h_lat[i] <= h_in[255-32*i -: 32];
                        end
`endif
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        v   <= v_nx;
                        w   <= w_nx;
                        cnt <= cnt + STEP;
                        if (cnt == LAST_CNT) begin
                            state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    ready <= 1'b1;
                    state <= IDLE;
                    if (!abort) begin
                        digest_q <= res;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: known vectors, handshake corners, random blocks.
// Expected digests follow SHA256_FEEDFWD_EN the same way the design does.
module tb_sha256_round_engine;

    localparam int P_UNROLL  = 1;
    localparam int P_OUT_REG = 1;
    localparam int LAT       = 64 / P_UNROLL + 1 + P_OUT_REG;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] STD_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] STD_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [255:0] h_in;
    logic [511:0] block_in;
    logic         ready;
    logic [255:0] digest;
    logic         done;

    int n_tests;
    int n_fail;

    sha256_round_engine #(
        .UNROLL (P_UNROLL),
        .OUT_REG(P_OUT_REG)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .h_in    (h_in),
        .block_in(block_in),
        .ready   (ready),
        .digest  (digest),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: full 64-entry schedule, named working variables.
    function automatic logic [255:0] ref_hash(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] wt [64];
        logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) wt[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            wt[i] = (rr(wt[i-2], 17) ^ rr(wt[i-2], 19) ^ (wt[i-2] >> 10)) + wt[i-7]
                  + (rr(wt[i-15], 7) ^ rr(wt[i-15], 18) ^ (wt[i-15] >> 3)) + wt[i-16];
        end
        {a, b, c, d, e, f, g, h} = hv;
        for (int i = 0; i < 64; i++) begin
            x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + wt[i];
            x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1;
            d = c; c = b; b = a; a = x1 + x2;
        end
        r = {a, b, c, d, e, f, g, h};
`ifdef SHA256_FEEDFWD_EN
        for (int i = 0; i < 8; i++) r[32*i +: 32] = r[32*i +: 32] + hv[32*i +: 32];
`endif
        return r;
    endfunction

    function automatic logic [255:0] expect_std(input logic [255:0] std);
        logic [255:0] r;
        r = std;
`ifndef SHA256_FEEDFWD_EN
        for (int i = 0; i < 8; i++) r[32*i +: 32] = std[32*i +: 32] - H0[32*i +: 32];
`endif
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge with ready high; returns at the negedge after the accept edge,
    // with the inputs scrambled to show they are latched.
    task automatic start_blk(input logic [255:0] hv, input logic [511:0] blk);
        start    = 1'b1;
        h_in     = hv;
        block_in = blk;
        @(negedge clk);
        start    = 1'b0;
        h_in     = rnd256();
        block_in = rnd512();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {255'd0, done}, 256'd1);
    endtask

    task automatic count_done(input int ncyc, output int k);
        k = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) k++;
        end
    endtask

    logic [255:0] exp_abc;
    logic [255:0] exp_empty;
    logic [255:0] hv_r;
    logic [511:0] blk_r;
    int           cyc;
    int           k;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        h_in     = '0;
        block_in = '0;
        exp_abc   = expect_std(STD_ABC);
        exp_empty = expect_std(STD_EMPTY);

        repeat (3) @(negedge clk);
        chk("rst_ready", {255'd0, ready}, 256'd1);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_digest", digest, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_blk(H0, BLK_ABC);
        chk("busy_ready", {255'd0, ready}, 256'd0);
        wait_done(cyc);
        chk("abc_lat", 256'(cyc), 256'(LAT));
        chk("abc_digest", digest, exp_abc);
        @(negedge clk);
        chk("done_pulse", {255'd0, done}, 256'd0);
        chk("digest_hold", digest, exp_abc);

        start_blk(H0, BLK_EMPTY);
        wait_done(cyc);
        chk("empty_lat", 256'(cyc), 256'(LAT));
        chk("empty_digest", digest, exp_empty);
        @(negedge clk);

        abort    = 1'b1;
        start    = 1'b1;
        h_in     = H0;
        block_in = BLK_ABC;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle_ready", {255'd0, ready}, 256'd1);
        count_done(LAT + 4, k);
        chk("abort_idle_nodone", 256'(k), 256'd0);

        start_blk(H0, BLK_ABC);
        wait_done(cyc);
        chk("b2b_first", digest, exp_abc);
        chk("b2b_ready", {255'd0, ready}, 256'(P_OUT_REG));
        start_blk(H0, BLK_EMPTY);
        wait_done(cyc);
        chk("b2b_gap", 256'(cyc), 256'(LAT));
        chk("b2b_second", digest, exp_empty);
        @(negedge clk);

        start    = 1'b1;
        h_in     = H0;
        block_in = BLK_ABC;
        cyc      = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            h_in     = rnd256();
            block_in = rnd512();
        end
        start = 1'b0;
        chk("held_lat", 256'(cyc), 256'(LAT));
        chk("held_digest", digest, exp_abc);
        @(negedge clk);

        start_blk(H0, BLK_EMPTY);
        repeat (30) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", {255'd0, ready}, 256'd1);
        chk("abort_done", {255'd0, done}, 256'd0);
        chk("abort_digest", digest, exp_abc);
        count_done(LAT + 4, k);
        chk("abort_nodone", 256'(k), 256'd0);
        start_blk(H0, BLK_ABC);
        wait_done(cyc);
        chk("rerun_digest", digest, exp_abc);
        @(negedge clk);

        for (int n = 0; n < 12; n++) begin
            hv_r  = rnd256();
            blk_r = rnd512();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_blk(hv_r, blk_r);
            wait_done(cyc);
            chk($sformatf("rnd%0d_lat", n), 256'(cyc), 256'(LAT));
            chk($sformatf("rnd%0d_digest", n), digest, ref_hash(hv_r, blk_r));
            @(negedge clk);
        end

        start_blk(H0, BLK_ABC);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {255'd0, ready}, 256'd1);
        chk("midrst_done", {255'd0, done}, 256'd0);
        chk("midrst_digest", digest, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(LAT + 4, k);
        chk("midrst_nodone", 256'(k), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
